caf_peak_hold: RTL and testbench

CAF_PEAK_HOLD -- requirements
Module: caf_peak_hold

---
 rtl/caf_peak_hold.sv | 143 ++++++++++++++
 tb/tb_caf_peak_hold.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_hold.sv
`default_nettype none
// ============================================================================
// Module      : caf_peak_hold
// Description : Per-frame peak search over cross-ambiguity results, one
//               result per frequency bin, with a threshold detect flag.
// Revision    : 1.0 - initial release
// ============================================================================
module caf_peak_hold #(
  parameter int unsigned out_max_bits = 5,
  parameter int unsigned index_bits   = 3,
  parameter int unsigned freq_bins    = 8,
  parameter int unsigned freq_bits    = 3,
  parameter int unsigned threshold    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [out_max_bits-1:0] out_max,
  input  logic [index_bits-1:0]   index,
  output logic                    s_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [out_max_bits-1:0] peak_max,
  output logic [index_bits-1:0]   peak_index,
  output logic [freq_bits-1:0]    peak_freq,
  output logic                    detect
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [freq_bits-1:0] c_last_bin  = freq_bits'(freq_bins - 1);
  localparam logic [freq_bits-1:0] c_bin_one   = freq_bits'(1);
  localparam logic [31:0]          c_threshold = 32'(threshold);

  state_t                  state_q, state_d;
  logic [freq_bits-1:0]    bin_q,   bin_d;
  logic                    valid_q, valid_d;
  logic [out_max_bits-1:0] max_q,   max_d;
  logic [index_bits-1:0]   idx_q,   idx_d;
  logic [freq_bits-1:0]    freq_q,  freq_d;
  logic                    det_q,   det_d;
  logic                    w_xfer;

  function automatic logic meets_threshold(input logic [out_max_bits-1:0] mag);
    return 32'(mag) >= c_threshold;
  endfunction

  // Ready is gated by reset so no transfer can be claimed while it is held.
  assign s_axis_tready = (state_q != S_DONE) && !reset;
  assign w_xfer        = m_axis_tvalid && s_axis_tready;

  assign s_axis_tvalid = valid_q;
  assign peak_max      = max_q;
  assign peak_index    = idx_q;
  assign peak_freq     = freq_q;
  assign detect        = det_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    valid_d = valid_q;
    max_d   = max_q;
    idx_d   = idx_q;
    freq_d  = freq_q;
    det_d   = det_q;

    case (state_q)
      S_IDLE: begin
        if (w_xfer) begin
          max_d  = out_max;
          idx_d  = index;
          freq_d = '0;
          det_d  = meets_threshold(out_max);
          bin_d  = c_bin_one;
          if (c_last_bin == '0) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end

      S_ACCUM: begin
        if (w_xfer) begin
          // Strict compare: on a tie the earlier bin keeps the peak.
          if (out_max > max_q) begin
            max_d  = out_max;
            idx_d  = index;
            freq_d = bin_q;
            det_d  = meets_threshold(out_max);
          end
          if (bin_q == c_last_bin) begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end else begin
            bin_d = bin_q + c_bin_one;
          end
        end
      end

      S_DONE: begin
        if (m_axis_tready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          bin_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        bin_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      valid_q <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
      freq_q  <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      det_q   <= det_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_caf_peak_hold.sv
`default_nettype none
// ============================================================================
// Module      : tb_caf_peak_hold
// Description : Scoreboard bench for caf_peak_hold with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_caf_peak_hold;

  localparam int FB = 8;
  localparam int TH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       m_axis_tvalid = 1'b0;
  logic       m_axis_tready = 1'b1;
  logic [4:0] out_max = '0;
  logic [2:0] index = '0;
  logic       s_axis_tready;
  logic       s_axis_tvalid;
  logic [4:0] peak_max;
  logic [2:0] peak_index;
  logic [2:0] peak_freq;
  logic       detect;

  always #5 clk = ~clk;

  caf_peak_hold #(
    .out_max_bits(5), .index_bits(3), .freq_bins(FB), .freq_bits(3), .threshold(TH)
  ) dut (
    .clk(clk), .reset(reset),
    .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
    .out_max(out_max), .index(index),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
    .peak_max(peak_max), .peak_index(peak_index), .peak_freq(peak_freq),
    .detect(detect)
  );

  typedef struct { int mx; int ix; int fq; int det; } res_t;

  res_t exp_q[$];
  int   fv[$];
  int   fi[$];
  int   total = 0;
  int   bad = 0;
  int   frames_expected = 0;
  int   frames_seen = 0;
  bit   exp_done = 1'b0;
  bit   hold_ok = 1'b0;
  res_t hold = '{0, 0, 0, 0};
  bit   bp_stop = 1'b0;

  int   a32[8] = '{3, 7, 2, 9, 9, 1, 4, 5};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame result from the rule: largest magnitude, first bin wins a tie.
  function automatic res_t frame_result();
    res_t r;
    int   best = 0;
    for (int b = 1; b < FB; b++)
      if (fv[b] > fv[best]) best = b;
    r.mx  = fv[best];
    r.ix  = fi[best];
    r.fq  = best;
    r.det = (fv[best] >= TH) ? 1 : 0;
    return r;
  endfunction

  // Reference model: protocol expectations and frame accumulation.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tvalid", int'(s_axis_tvalid), 0);
      chk("rst_tready", int'(s_axis_tready), 0);
      chk("rst_peak_max", int'(peak_max), 0);
      chk("rst_peak_index", int'(peak_index), 0);
      chk("rst_peak_freq", int'(peak_freq), 0);
      chk("rst_detect", int'(detect), 0);
      frames_expected -= exp_q.size();
      exp_q.delete();
      fv.delete();
      fi.delete();
      exp_done = 1'b0;
      hold     = '{0, 0, 0, 0};
      hold_ok  = 1'b1;
    end else begin
      chk("tvalid", int'(s_axis_tvalid), int'(exp_done));
      chk("tready", int'(s_axis_tready), int'(!exp_done));
      if (hold_ok) begin
        chk("hold_peak_max", int'(peak_max), hold.mx);
        chk("hold_peak_index", int'(peak_index), hold.ix);
        chk("hold_peak_freq", int'(peak_freq), hold.fq);
        chk("hold_detect", int'(detect), hold.det);
      end
      if (exp_done) begin
        if (m_axis_tready) exp_done = 1'b0;
      end else if (m_axis_tvalid) begin
        hold_ok = 1'b0;
        fv.push_back(int'(out_max));
        fi.push_back(int'(index));
        if (fv.size() == FB) begin
          hold = frame_result();
          exp_q.push_back(hold);
          frames_expected++;
          hold_ok  = 1'b1;
          exp_done = 1'b1;
          fv.delete();
          fi.delete();
        end
      end
    end
  end

  // Scoreboard monitor: compares every presented frame result.
  always @(negedge clk) begin
    if (!reset && s_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got frame peak_max=%0d expected no frame at %0t", peak_max, $time);
      end else begin
        chk("sb_peak_max", int'(peak_max), exp_q[0].mx);
        chk("sb_peak_index", int'(peak_index), exp_q[0].ix);
        chk("sb_peak_freq", int'(peak_freq), exp_q[0].fq);
        chk("sb_detect", int'(detect), exp_q[0].det);
        if (m_axis_tready) begin
          void'(exp_q.pop_front());
          frames_seen++;
        end
      end
    end
  end

  task automatic idle(input int n);
    m_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v, input int ix);
    bit acc   = 1'b0;
    int guard = 0;
    m_axis_tvalid = 1'b1;
    out_max       = 5'(v);
    index         = 3'(ix);
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    m_axis_tvalid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no s_axis_tready in %0d cycles expected accept", guard);
    end
  endtask

  task automatic rand_frame(input bit gaps);
    for (int b = 0; b < FB; b++) begin
      if (gaps) idle($urandom_range(0, 2));
      send($urandom_range(0, 31), $urandom_range(0, 7));
    end
  endtask

  task automatic pulse_reset();
    m_axis_tvalid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    idle(3);
    reset = 1'b0;

    for (int i = 0; i < FB; i++) send(a32[i], i);
    idle(3);

    for (int i = 0; i < FB; i++) send(20, 6);
    idle(3);

    // Downstream stall with upstream already offering the next frame.
    m_axis_tready = 1'b0;
    rand_frame(1'b0);
    fork
      send(5, 1);
      begin
        idle(10);
        m_axis_tready = 1'b1;
      end
    join
    for (int i = 1; i < FB; i++) send($urandom_range(0, 31), i);
    idle(3);

    for (int b = 0; b < FB; b++) begin
      for (int g = 0; g < 20 && $urandom_range(0, 1) == 1; g++) idle(1);
      send((b == 7) ? 31 : $urandom_range(0, 30), $urandom_range(0, 7));
    end
    idle(3);

    for (int i = 0; i < 4; i++) send(31 - i, i);
    pulse_reset();
    for (int i = 0; i < FB; i++) send(i + 1, $urandom_range(0, 7));
    idle(3);

    m_axis_tready = 1'b0;
    rand_frame(1'b1);
    idle(2);
    pulse_reset();
    m_axis_tready = 1'b1;
    idle(2);

    for (int f = 0; f < 3; f++) rand_frame(1'b0);
    idle(3);

    fork
      begin
        while (!bp_stop) begin
          @(posedge clk);
          #1;
          m_axis_tready = 1'($urandom_range(0, 1));
        end
        m_axis_tready = 1'b1;
      end
      begin
        for (int f = 0; f < 5; f++) rand_frame(1'b1);
        bp_stop = 1'b1;
      end
    join

    idle(6);
    chk("queue_drained", exp_q.size(), 0);
    chk("frames_seen", frames_seen, frames_expected);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1);
  end

endmodule
`default_nettype wire
